regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 134 +++++++++++++
 tb/tb_regfile_mp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : regfile_mp
// Description : Multi-read, dual-write register file with same-cycle write
//               bypass, per-register busy scoreboard and a clear-on-reset sweep.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  set_busy,
    input  logic [ADDR_W-1:0]     busy_addr,
    output logic [NRD-1:0]        rbusy,
    output logic                  init_done
);

    localparam int              c_nreg   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(c_nreg - 1);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic [DATA_W-1:0] r_mem [c_nreg];
    logic [c_nreg-1:0] r_busy;
    logic [c_nreg-1:0] w_busy_nxt;

    logic w_run;
    logic w_wr0;
    logic w_wr1;
    logic w_set;

    // Outputs must read as idle during the reset cycle itself, not just after it.
    assign w_run     = (r_state == S_RUN) && !rst;
    assign init_done = w_run;

    assign w_wr0 = w_run && we0 && (waddr0 != '0);
    assign w_wr1 = w_run && we1 && (waddr1 != '0);
    assign w_set = w_run && set_busy && (busy_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Storage is not reset; the INIT sweep zeroes every entry instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wr0) r_mem[waddr0] <= wdata0;
                if (w_wr1) r_mem[waddr1] <= wdata1;
            end
        end
    end

    // Clears applied before the set so a new producer keeps the entry busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0) w_busy_nxt[waddr0] = 1'b0;
        if (w_wr1) w_busy_nxt[waddr1] = 1'b0;
        if (w_set) w_busy_nxt[busy_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic              w_en;
            logic              w_byp1;
            logic              w_byp0;

            assign w_ra   = raddr[gi*ADDR_W +: ADDR_W];
            assign w_en   = w_run && re[gi] && (w_ra != '0);
            assign w_byp1 = w_wr1 && (waddr1 == w_ra);
            assign w_byp0 = w_wr0 && (waddr0 == w_ra);

            assign rdata[gi*DATA_W +: DATA_W] = !w_en  ? '0     :
                                                w_byp1 ? wdata1 :
                                                w_byp0 ? wdata0 :
                                                         r_mem[w_ra];
            assign rbusy[gi] = w_en && !w_byp1 && !w_byp0 && r_busy[w_ra];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_regfile_mp
// Description : Randomized and directed checks of regfile_mp against a model.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic              set_busy;
    logic [AW-1:0]     busy_addr;
    logic [NRD-1:0]    rbusy;
    logic              init_done;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) u_dut (
        .clk(clk), .rst(rst),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata),
        .set_busy(set_busy), .busy_addr(busy_addr),
        .rbusy(rbusy), .init_done(init_done)
    );

    // Reference model: contents, busy flags and cycles elapsed since reset.
    logic [DW-1:0] m_regs [NREG];
    logic          m_busy [NREG];
    int            m_cyc;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_run();
        return !rst && (m_cyc >= NREG);
    endfunction

    function automatic int rd_addr(int i);
        return int'(raddr[i*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] exp_rdata(int i);
        int a = rd_addr(i);
        if (!m_run() || !re[i] || a == 0) return '0;
        if (we1 && int'(waddr1) == a) return wdata1;
        if (we0 && int'(waddr0) == a) return wdata0;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(int i);
        int a = rd_addr(i);
        if (!m_run() || !re[i] || a == 0) return 1'b0;
        if ((we1 && int'(waddr1) == a) || (we0 && int'(waddr0) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_rdata(i));
            chk($sformatf("rbusy%0d", i), DW'(rbusy[i]), DW'(exp_rbusy(i)));
        end
        chk("init_done", DW'(init_done), DW'(m_run()));
    endtask

    task automatic model_update();
        if (rst) begin
            m_cyc = 0;
            for (int k = 0; k < NREG; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else if (m_cyc < NREG) begin
            m_cyc++;
        end else begin
            if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (set_busy && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        re = '0; raddr = '0; set_busy = 0; busy_addr = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 100) begin
            step();
            n++;
        end
        chk(tag, DW'(n), DW'(NREG));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        m_cyc = 0;
        for (int k = 0; k < NREG; k++) begin m_regs[k] = 'x; m_busy[k] = 1'b0; end
        @(negedge clk);
        set_rd(0, 4);
        step();
        step();
        rst = 1'b0;
        idle();
        wait_init("init_latency");

        for (int a = 1; a < NREG; a++) begin
            idle(); set_rd(0, a); set_rd(1, NREG - a);
            #1 chk("swept_zero", rdata[0 +: DW], '0);
            step();
        end

        idle(); we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; set_rd(0, 5);
        #1 chk("bypass_we0", rdata[0 +: DW], 32'hDEADBEEF);
        step();
        idle(); set_rd(0, 5);
        #1 chk("stored_5", rdata[0 +: DW], 32'hDEADBEEF);
        step();

        idle(); we0 = 1; we1 = 1; waddr0 = 7; waddr1 = 7; wdata0 = 32'h11; wdata1 = 32'h22;
        set_rd(1, 7);
        #1 chk("bypass_both", rdata[DW +: DW], 32'h22);
        step();
        idle(); set_rd(0, 7); set_rd(1, 7);
        #1 chk("port1_wins", rdata[0 +: DW], 32'h22);
        chk("ports_agree", rdata[DW +: DW], 32'h22);
        step();

        idle(); we0 = 1; waddr0 = 0; wdata0 = 32'h55;
        step();
        idle(); set_rd(0, 0); set_busy = 1; busy_addr = 0;
        #1 chk("reg0_zero", rdata[0 +: DW], '0);
        step();
        idle(); set_rd(0, 0);
        #1 chk("reg0_nobusy", DW'(rbusy[0]), '0);
        step();

        idle(); set_busy = 1; busy_addr = 3;
        step();
        idle(); set_rd(0, 3);
        #1 chk("busy3_set", DW'(rbusy[0]), 32'd1);
        step();
        idle(); we1 = 1; waddr1 = 3; wdata1 = 32'h33; set_busy = 1; busy_addr = 3;
        step();
        idle(); set_rd(1, 3);
        #1 chk("busy3_set_wins", DW'(rbusy[1]), 32'd1);
        step();
        idle(); we0 = 1; waddr0 = 3; wdata0 = 32'h44;
        step();
        idle(); set_rd(1, 3);
        #1 chk("busy3_cleared", DW'(rbusy[1]), '0);
        step();

        idle(); rst = 1; step(); rst = 0;
        for (int k = 0; k < 10; k++) step();
        rst = 1; step(); rst = 0;
        wait_init("init_restart_mid");
        idle(); we1 = 1; waddr1 = 9; wdata1 = 32'h1234;
        step();
        idle(); set_rd(0, 9);
        #1 chk("reg9_written", rdata[0 +: DW], 32'h1234);
        rst = 1; step(); rst = 0;
        wait_init("init_restart_run");
        idle(); set_rd(0, 9);
        #1 chk("reg9_cleared", rdata[0 +: DW], '0);
        step();

        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
            waddr0 = AW'($urandom_range(0, 7)); waddr1 = AW'($urandom_range(0, 7));
            wdata0 = $urandom; wdata1 = $urandom;
            re = NRD'($urandom);
            for (int p = 0; p < NRD; p++)
                raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            set_busy = $urandom_range(0, 1);
            busy_addr = AW'($urandom_range(0, 7));
            step();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
